// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - memory-side responder for cache fetch write/read bursts
// Grants one burst at a time and services it against a word-addressed storage array.
module burst_mem_responder #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int mem_depth  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    output logic                  wr_gnt,
    input  logic [15:0]           wr_len,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_last,
    output logic                  wr_done,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    input  logic [15:0]           rd_len,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_done,
    output logic                  proto_err
);
    localparam int LB = $clog2(data_width / 8);
    localparam int AW = $clog2(mem_depth);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_DATA, RD_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [15:0]     n_q, n_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            proto_err_q, proto_err_d;
    logic [1:0]      buf_cnt_q, buf_cnt_d;
    logic            buf_rp_q, buf_rp_d;
    logic            buf_wp_q, buf_wp_d;

    logic [data_width-1:0] mem_q [mem_depth];
    logic [data_width-1:0] buf_data_q [2];
    logic                  buf_last_q [2];

    logic [15:0]     wr_beats_raw, rd_beats_raw, wr_beats, rd_beats;
    logic [AW-1:0]   wr_word, rd_word;
    logic            wr_hs, rd_pop, rd_issue, last_beat;
    logic            unused_addr;

    assign wr_beats_raw = wr_len >> LB;
    assign rd_beats_raw = rd_len >> LB;
    assign wr_beats     = (wr_beats_raw == 16'd0) ? 16'd1 : wr_beats_raw;
    assign rd_beats     = (rd_beats_raw == 16'd0) ? 16'd1 : rd_beats_raw;
    assign wr_word      = wr_addr[LB +: AW];
    assign rd_word      = rd_addr[LB +: AW];
    assign unused_addr  = ^{wr_addr, rd_addr, wr_len, rd_len};

    assign last_beat = (cnt_q == n_q - 16'd1);
    assign wr_hs     = (state_q == WR_DATA) && wr_valid;
    assign rd_pop    = (buf_cnt_q != 2'd0) && rd_ready;
    // A read may issue while fewer than two beats are in the buffer after this cycle's pop.
    assign rd_issue  = (state_q == RD_DATA) && ((buf_cnt_q < 2'd2) || rd_pop);

    assign wr_gnt    = !rst && (state_q == IDLE) && wr_req;
    assign rd_gnt    = !rst && (state_q == IDLE) && rd_req && !wr_req;
    assign wr_ready  = (state_q == WR_DATA);
    assign wr_done   = (state_q == WR_RESP);
    assign rd_valid  = (buf_cnt_q != 2'd0);
    assign rd_data   = rd_valid ? buf_data_q[buf_rp_q] : '0;
    assign rd_done   = rd_valid && buf_last_q[buf_rp_q];
    assign proto_err = proto_err_q;

    assign buf_cnt_d = buf_cnt_q + {1'b0, rd_issue} - {1'b0, rd_pop};
    assign buf_wp_d  = buf_wp_q ^ rd_issue;
    assign buf_rp_d  = buf_rp_q ^ rd_pop;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    ptr_d   = wr_word;
                    n_d     = wr_beats;
                    cnt_d   = 16'd0;
                    state_d = WR_DATA;
                end else if (rd_req) begin
                    ptr_d   = rd_word;
                    n_d     = rd_beats;
                    cnt_d   = 16'd0;
                    state_d = RD_DATA;
                end
            end
            WR_DATA: begin
                if (wr_hs) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (wr_last != last_beat) begin
                        proto_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: state_d = IDLE;
            RD_DATA: begin
                if (rd_issue) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (last_beat) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (rd_pop && buf_last_q[buf_rp_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            n_q         <= 16'd0;
            cnt_q       <= 16'd0;
            proto_err_q <= 1'b0;
            buf_cnt_q   <= 2'd0;
            buf_rp_q    <= 1'b0;
            buf_wp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            buf_cnt_q   <= buf_cnt_d;
            buf_rp_q    <= buf_rp_d;
            buf_wp_q    <= buf_wp_d;
        end
    end

    // Storage keeps its contents across reset; the buffer entry doubles as the read register.
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem_q[ptr_q] <= wr_data;
        end
        if (rd_issue) begin
            buf_data_q[buf_wp_q] <= mem_q[ptr_q];
            buf_last_q[buf_wp_q] <= last_beat;
        end
    end
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - self-checking bench for burst_mem_responder
// Random data and handshakes are checked against a word-array reference of the memory.
module tb_burst_mem_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, wr_gnt, wr_valid, wr_ready, wr_last, wr_done;
    logic [15:0] wr_len, rd_len;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic        rd_req, rd_gnt, rd_valid, rd_ready, rd_done, proto_err;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] got_data [$];
    logic        got_done [$];
    int          n_checks = 0;
    int          n_fail = 0;

    burst_mem_responder dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_len(wr_len), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_last(wr_last),
        .wr_done(wr_done),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_done(rd_done),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic int beats_of(input logic [15:0] len);
        return (len / 4 == 0) ? 1 : int'(len / 4);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [15:0] len, input int last_idx,
                            input bit use_base, input logic [31:0] base, input int gap_pct,
                            output bit gnt_ok, output int wcycles, output int done_lat,
                            output int done_cnt, output int pe_cycle, output int rdgnt_lat,
                            output bit early_rdgnt);
        int n, w, i, c, lastc;
        logic [31:0] d;
        n = beats_of(len);
        w = word_of(addr);
        gnt_ok = 0; wcycles = -1; done_lat = -1; done_cnt = 0; pe_cycle = -1;
        rdgnt_lat = -1; early_rdgnt = 0;
        wr_req = 1; wr_addr = addr; wr_len = len; wr_valid = 0; wr_last = 0;
        @(negedge clk);
        gnt_ok = wr_gnt;
        if (rd_gnt) early_rdgnt = 1;
        @(posedge clk); #1;
        wr_req = 0; wr_addr = $urandom; wr_len = 16'($urandom);
        i = 0; c = 1;
        while (i < n && c < 2000) begin
            d = use_base ? base + 32'(i) : $urandom;
            wr_valid = ($urandom_range(0, 99) >= gap_pct);
            wr_data = d;
            wr_last = (i == last_idx);
            @(negedge clk);
            if (proto_err && pe_cycle < 0) pe_cycle = c;
            if (rd_gnt) early_rdgnt = 1;
            if (wr_valid && wr_ready) begin
                ref_mem[(w + i) % DEPTH] = d;
                i++;
                if (i == n) wcycles = c;
            end
            @(posedge clk); #1;
            c++;
        end
        wr_valid = 0; wr_last = 0;
        lastc = c - 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (proto_err && pe_cycle < 0) pe_cycle = c;
            if (wr_done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = c - lastc;
            end
            if (rd_gnt && rdgnt_lat < 0) rdgnt_lat = c - lastc;
            @(posedge clk); #1;
            c++;
            if (rdgnt_lat >= 0) begin
                rd_req = 0;
                break;
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] len, input bit pregranted,
                           input int stall_beat, input int stall_len, input bit rand_ready,
                           input int abort_beat, output bit gnt_ok, output int first_lat,
                           output int last_c, output bit hold_ok, output bit extra_valid,
                           output logic [3:0] rst_obs);
        int n, c, got, sl;
        logic [31:0] held;
        got_data.delete(); got_done.delete();
        gnt_ok = pregranted; first_lat = -1; last_c = -1; hold_ok = 1; extra_valid = 0;
        rst_obs = 4'hF; sl = stall_len; held = '0;
        n = beats_of(len);
        if (!pregranted) begin
            rd_req = 1; rd_addr = addr; rd_len = len; rd_ready = 0;
            @(negedge clk);
            gnt_ok = rd_gnt;
            @(posedge clk); #1;
            rd_req = 0; rd_addr = $urandom; rd_len = 16'($urandom);
        end
        c = 1; got = 0;
        while (got < n && c < 2000) begin
            if (abort_beat >= 0 && got == abort_beat && rd_valid) begin
                rst = 1;
                #1;
                rst_obs = {rd_valid, rd_done, proto_err, (rd_data != 32'h0)};
                rd_ready = 0;
                return;
            end
            if (rd_valid && got == stall_beat && sl > 0) begin
                if (sl == stall_len) held = rd_data;
                else if (rd_data !== held) hold_ok = 0;
                rd_ready = 0;
                sl--;
            end else begin
                rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            if (rd_valid && first_lat < 0) first_lat = c;
            if (rd_valid && rd_ready) begin
                if (stall_len > 0 && got == stall_beat && rd_data !== held) hold_ok = 0;
                got_data.push_back(rd_data);
                got_done.push_back(rd_done);
                got++;
                last_c = c;
            end
            @(posedge clk); #1;
            c++;
        end
        if (sl != 0) hold_ok = 0;
        rd_ready = 0;
        @(negedge clk);
        extra_valid = rd_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; wr_req = 1; rd_req = 1; wr_valid = 1; rd_ready = 1; wr_last = 1;
        @(negedge clk);
        n_checks++;
        if ({wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done, proto_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done, proto_err});
        end
        n_checks++;
        if (rd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd_data: got %h, expected 0", rd_data);
        end
        wr_req = 0; rd_req = 0; wr_valid = 0; rd_ready = 0; wr_last = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({wr_ready, wr_done, rd_valid, proto_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b, expected 0000",
                     {wr_ready, wr_done, rd_valid, proto_err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        bit g, ev, hold, erg;
        int wc, dl, dc, pe, rg, fl, lc;
        logic [3:0] ro;
        do_write(32'h100, 16'd128, 31, 1, 32'hA000_0000, 0, g, wc, dl, dc, pe, rg, erg);
        n_checks++;
        if (g !== 1'b1) begin n_fail++; $display("FAIL wr_gnt_same_cycle: got %0d, expected 1", g); end
        n_checks++;
        if (wc !== 32) begin n_fail++; $display("FAIL wr_32_beats_cycles: got %0d, expected 32", wc); end
        n_checks++;
        if (dl !== 1 || dc !== 1) begin
            n_fail++; $display("FAIL wr_done_timing: got lat %0d cnt %0d, expected lat 1 cnt 1", dl, dc);
        end
        do_read(32'h100, 16'd128, 0, -1, 0, 0, -1, g, fl, lc, hold, ev, ro);
        n_checks++;
        if (g !== 1'b1 || fl !== 2) begin
            n_fail++; $display("FAIL rd_first_valid: got gnt %0d lat %0d, expected gnt 1 lat 2", g, fl);
        end
        n_checks++;
        if (lc !== 33 || got_data.size() !== 32) begin
            n_fail++; $display("FAIL rd_back_to_back: got last %0d beats %0d, expected 33 32", lc, got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== 32'hA000_0000 + 32'(i) || got_done[i] !== (i == 31)) begin
                n_fail++;
                $display("FAIL rd_beat_%0d: got %h done %0d, expected %h done %0d",
                         i, got_data[i], got_done[i], 32'hA000_0000 + 32'(i), (i == 31));
            end
        end
        n_checks++;
        if (ev !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_drain_clean: got valid %0d err %0d, expected 0 0", ev, proto_err);
        end
    endtask

    task automatic test_simultaneous();
        bit g, erg, hold, ev;
        int wc, dl, dc, pe, rg, fl, lc, w;
        logic [3:0] ro;
        rd_req = 1; rd_addr = 32'h100; rd_len = 16'd16;
        do_write(32'h200, 16'd16, 3, 0, 32'h0, 0, g, wc, dl, dc, pe, rg, erg);
        n_checks++;
        if (g !== 1'b1 || erg !== 1'b0) begin
            n_fail++; $display("FAIL simul_write_wins: got wr_gnt %0d rd_gnt_early %0d, expected 1 0", g, erg);
        end
        n_checks++;
        if (dl !== 1 || rg !== 2) begin
            n_fail++; $display("FAIL simul_rd_gnt_after_idle: got done %0d gnt %0d, expected 1 2", dl, rg);
        end
        rd_req = 0;
        do_read(32'h100, 16'd16, 1, -1, 0, 0, -1, g, fl, lc, hold, ev, ro);
        w = word_of(32'h100);
        n_checks++;
        if (fl !== 2 || got_data.size() !== 4) begin
            n_fail++; $display("FAIL simul_read: got lat %0d beats %0d, expected 2 4", fl, got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== ref_mem[(w + i) % DEPTH]) begin
                n_fail++; $display("FAIL simul_beat_%0d: got %h, expected %h", i, got_data[i], ref_mem[(w + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit g, erg, hold, ev;
        int wc, dl, dc, pe, rg, fl, lc_a, lc_b, w;
        logic [3:0] ro;
        do_write(32'h400, 16'd32, 7, 0, 32'h0, 0, g, wc, dl, dc, pe, rg, erg);
        do_read(32'h400, 16'd32, 0, -1, 0, 0, -1, g, fl, lc_a, hold, ev, ro);
        do_read(32'h400, 16'd32, 0, 2, 3, 0, -1, g, fl, lc_b, hold, ev, ro);
        w = word_of(32'h400);
        n_checks++;
        if (lc_a !== 9 || lc_b - lc_a !== 3) begin
            n_fail++; $display("FAIL stall_duration: got %0d then %0d, expected 9 then 12", lc_a, lc_b);
        end
        n_checks++;
        if (hold !== 1'b1) begin n_fail++; $display("FAIL stall_hold_stable: got %0d, expected 1", hold); end
        n_checks++;
        if (got_data.size() !== 8) begin
            n_fail++; $display("FAIL stall_beat_count: got %0d, expected 8", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== ref_mem[(w + i) % DEPTH] || got_done[i] !== (i == 7)) begin
                n_fail++; $display("FAIL stall_beat_%0d: got %h done %0d, expected %h done %0d",
                                   i, got_data[i], got_done[i], ref_mem[(w + i) % DEPTH], (i == 7));
            end
        end
    endtask

    task automatic test_wrap();
        bit g, erg, hold, ev;
        int wc, dl, dc, pe, rg, fl, lc;
        logic [3:0] ro;
        do_write(32'(1022 * 4), 16'd16, 3, 1, 32'hC0DE_0000, 0, g, wc, dl, dc, pe, rg, erg);
        do_read(32'(1022 * 4), 16'd16, 0, -1, 0, 0, -1, g, fl, lc, hold, ev, ro);
        n_checks++;
        if (got_data.size() !== 4) begin
            n_fail++; $display("FAIL wrap_beat_count: got %0d, expected 4", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== 32'hC0DE_0000 + 32'(i)) begin
                n_fail++; $display("FAIL wrap_beat_%0d: got %h, expected %h", i, got_data[i], 32'hC0DE_0000 + 32'(i));
            end
        end
        do_read(32'h0, 16'd8, 0, -1, 0, 0, -1, g, fl, lc, hold, ev, ro);
        n_checks++;
        if (got_data.size() !== 2 || got_data[0] !== 32'hC0DE_0002 || got_data[1] !== 32'hC0DE_0003) begin
            n_fail++; $display("FAIL wrap_word0_word1: got %0d beats %h %h, expected 2 beats c0de0002 c0de0003",
                               got_data.size(), got_data[0], got_data[1]);
        end
    endtask

    task automatic test_random();
        bit g, erg, hold, ev;
        int wc, dl, dc, pe, rg, fl, lc, w, n;
        logic [31:0] a, e;
        logic [15:0] len;
        logic [3:0] ro;
        for (int it = 0; it < 10; it++) begin
            a = 32'($urandom_range(0, 8191));
            len = (it == 0) ? 16'd0 : (it == 1) ? 16'd3 : 16'($urandom_range(0, 70));
            n = beats_of(len);
            w = word_of(a);
            do_write(a, len, n - 1, 0, 32'h0, 30, g, wc, dl, dc, pe, rg, erg);
            n_checks++;
            if (dc !== 1) begin n_fail++; $display("FAIL rand_wr_done_%0d: got %0d, expected 1", it, dc); end
            do_read(a, len, 0, -1, 0, 1, -1, g, fl, lc, hold, ev, ro);
            n_checks++;
            if (got_data.size() !== n) begin
                n_fail++; $display("FAIL rand_beats_%0d: got %0d, expected %0d", it, got_data.size(), n);
            end
            for (int i = 0; i < got_data.size(); i++) begin
                e = ref_mem[(w + i) % DEPTH];
                n_checks++;
                if (got_data[i] !== e || got_done[i] !== (i == n - 1)) begin
                    n_fail++; $display("FAIL rand_%0d_beat_%0d: got %h done %0d, expected %h done %0d",
                                       it, i, got_data[i], got_done[i], e, (i == n - 1));
                end
            end
        end
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rand_no_proto_err: got %0d, expected 0", proto_err); end
    endtask

    task automatic test_proto_err();
        bit g, erg;
        int wc, dl, dc, pe, rg;
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_err_before: got %0d, expected 0", proto_err); end
        do_write(32'h800, 16'd16, 1, 0, 32'h0, 0, g, wc, dl, dc, pe, rg, erg);
        n_checks++;
        if (pe !== 3) begin n_fail++; $display("FAIL proto_err_cycle: got %0d, expected 3", pe); end
        n_checks++;
        if (wc !== 4 || dc !== 1 || dl !== 1) begin
            n_fail++; $display("FAIL proto_burst_continues: got cycles %0d done %0d lat %0d, expected 4 1 1", wc, dc, dl);
        end
        n_checks++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_err_sticky: got %0d, expected 1", proto_err); end
    endtask

    task automatic test_reset_midburst();
        bit g, erg, hold, ev;
        int wc, dl, dc, pe, rg, fl, lc, w;
        logic [3:0] ro;
        do_read(32'h100, 16'd64, 0, -1, 0, 0, 5, g, fl, lc, hold, ev, ro);
        n_checks++;
        if (ro !== 4'b0000 || got_data.size() !== 5) begin
            n_fail++; $display("FAIL midburst_reset_outputs: got %b after %0d beats, expected 0000 after 5", ro, got_data.size());
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({rd_valid, wr_ready, wr_done, proto_err} !== 4'b0) begin
            n_fail++; $display("FAIL midburst_idle: got %b, expected 0000", {rd_valid, wr_ready, wr_done, proto_err});
        end
        @(posedge clk); #1;
        do_write(32'h600, 16'd4, 0, 0, 32'h0, 0, g, wc, dl, dc, pe, rg, erg);
        n_checks++;
        if (g !== 1'b1 || wc !== 1 || dc !== 1) begin
            n_fail++; $display("FAIL post_reset_write: got gnt %0d cycles %0d done %0d, expected 1 1 1", g, wc, dc);
        end
        do_read(32'h600, 16'd4, 0, -1, 0, 0, -1, g, fl, lc, hold, ev, ro);
        n_checks++;
        if (got_data.size() !== 1 || got_data[0] !== ref_mem[word_of(32'h600)] || got_done[0] !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_read: got %0d beats %h, expected 1 beat %h", got_data.size(), got_data[0], ref_mem[word_of(32'h600)]);
        end
        do_read(32'h100, 16'd128, 0, -1, 0, 1, -1, g, fl, lc, hold, ev, ro);
        w = word_of(32'h100);
        n_checks++;
        if (got_data.size() !== 32) begin
            n_fail++; $display("FAIL intact_beats: got %0d, expected 32", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== ref_mem[(w + i) % DEPTH]) begin
                n_fail++; $display("FAIL intact_word_%0d: got %h, expected %h", i, got_data[i], ref_mem[(w + i) % DEPTH]);
            end
        end
    endtask

    initial begin
        rst = 1; wr_req = 0; rd_req = 0; wr_valid = 0; wr_last = 0; rd_ready = 0;
        wr_len = 0; rd_len = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_backpressure();
        test_wrap();
        test_random();
        test_proto_err();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
